// File: rtl/flash_spi_pkg.sv
// Shared types and constants for the configuration-flash SPI reader.
`timescale 1ns/1ps
package flash_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    WAIT,
    HOLD
  } state_t;

  localparam logic [7:0] OP_READ            = 8'h03;
  localparam logic [7:0] OP_READ_STATUS     = 8'h05;
  localparam logic [7:0] OP_READ_SILICON_ID = 8'hAB;

  localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/flash_spi_shifter.sv
// Mode-0 byte shifter: DCLK divider, bit counter and tx/rx shift registers.
`timescale 1ns/1ps
module flash_spi_shifter
  import flash_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [7:0] i_load_data,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_miso,
  output logic       o_dclk,
  output logic       o_mosi,
  output logic       o_done,
  output logic [7:0] o_rx
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]     r_div_cnt;
  logic                 r_phase;
  logic                 r_active;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [7:0]           r_tx;
  logic [7:0]           r_rx;
  logic                 r_dclk;
  logic                 w_tick;

  // One tick per DCLK half-period; phase 0 ends in a rise, phase 1 in a fall.
  assign w_tick = r_active && (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign o_done = w_tick && r_phase && (r_bit_cnt == '1);
  assign o_dclk = r_dclk;
  assign o_mosi = r_tx[7];
  assign o_rx   = r_rx;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
      r_active  <= 1'b0;
      r_bit_cnt <= '0;
      r_tx      <= 8'h00;
      r_rx      <= 8'h00;
      r_dclk    <= 1'b0;
    end else if (i_abort) begin
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
      r_active  <= 1'b0;
      r_bit_cnt <= '0;
      r_tx      <= 8'h00;
      r_dclk    <= 1'b0;
    end else begin
      if (i_load) begin
        r_tx <= i_load_data;
      end
      if (i_start) begin
        r_active  <= 1'b1;
        r_phase   <= 1'b0;
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_dclk    <= 1'b0;
      end else if (w_tick) begin
        r_div_cnt <= '0;
        r_phase   <= ~r_phase;
        if (!r_phase) begin
          r_dclk <= 1'b1;
          r_rx   <= {r_rx[6:0], i_miso};
        end else begin
          r_dclk    <= 1'b0;
          r_tx      <= {r_tx[6:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == '1) begin
            r_active <= 1'b0;
          end
        end
      end else if (r_active) begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/flash_spi_reader.sv
// Byte-exchange SPI master for the configuration flash; chip select spans
// the whole FLASH_enable window so multi-byte commands form one transaction.
`timescale 1ns/1ps
module flash_spi_reader
  import flash_spi_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 4
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic [7:0] FLASH_data_out,
  input  logic       FLASH_enable,
  input  logic       FLASH_continue_read,
  output logic [7:0] FLASH_data_in,
  output logic       FLASH_busy,
  output logic       FLASH_DCLK,
  output logic       FLASH_NCSO,
  output logic       FLASH_ASDO,
  input  logic       FLASH_DATA0
);

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           r_state;
  logic             r_enable_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ncso;
  logic             r_busy;
  logic [7:0]       r_data_in;

  logic       w_rise;
  logic       w_next_byte;
  logic       w_load;
  logic       w_start;
  logic       w_abort;
  logic       w_done;
  logic [7:0] w_rx;

  assign w_rise      = FLASH_enable && !r_enable_d;
  // Enable low in WAIT beats a simultaneous continue pulse.
  assign w_next_byte = (r_state == WAIT) && FLASH_enable && FLASH_continue_read;
  assign w_load      = ((r_state == IDLE) && w_rise) || w_next_byte;
  assign w_start     = ((r_state == SETUP) && FLASH_enable &&
                        (r_cnt == CNT_W'(CS_SETUP - 1))) || w_next_byte;
  assign w_abort     = ((r_state == SETUP) || (r_state == SHIFT)) && !FLASH_enable;

  flash_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .i_load      (w_load),
    .i_load_data (FLASH_data_out),
    .i_start     (w_start),
    .i_abort     (w_abort),
    .i_miso      (FLASH_DATA0),
    .o_dclk      (FLASH_DCLK),
    .o_mosi      (FLASH_ASDO),
    .o_done      (w_done),
    .o_rx        (w_rx)
  );

  assign FLASH_NCSO    = r_ncso;
  assign FLASH_busy    = r_busy;
  assign FLASH_data_in = r_data_in;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_enable_d <= 1'b0;
      r_cnt      <= '0;
      r_ncso     <= 1'b1;
      r_busy     <= 1'b1;
      r_data_in  <= 8'h00;
    end else begin
      r_enable_d <= FLASH_enable;
      case (r_state)
        IDLE: begin
          r_ncso <= 1'b1;
          r_busy <= 1'b1;
          if (w_rise) begin
            r_ncso  <= 1'b0;
            r_cnt   <= '0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (!FLASH_enable) begin
            r_ncso  <= 1'b1;
            r_cnt   <= '0;
            r_state <= HOLD;
          end else if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
            r_state <= SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!FLASH_enable) begin
            r_ncso  <= 1'b1;
            r_cnt   <= '0;
            r_state <= HOLD;
          end else if (w_done) begin
            r_data_in <= w_rx;
            r_busy    <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (!FLASH_enable) begin
            r_ncso  <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= HOLD;
          end else if (FLASH_continue_read) begin
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        HOLD: begin
          r_ncso <= 1'b1;
          r_busy <= 1'b1;
          if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_ncso  <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
